// File: rtl/id_decode_pipe_if.sv
// Signal bundle for the ID stage: fetch-side handshake, hazard controls,
// write-back and forwarding ports, ID/EX register outputs and branch redirect.
interface id_decode_pipe_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_instr;

  logic            hz_stall;
  logic            flush;

  logic            wb_we;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            mem_we;
  logic [AW-1:0]   mem_rd;
  logic [XLEN-1:0] mem_data;

  logic            out_valid;
  logic            out_ready;
  logic [AW-1:0]   out_rs1;
  logic [AW-1:0]   out_rs2;
  logic [AW-1:0]   out_rd;
  logic [XLEN-1:0] out_rs1_data;
  logic [XLEN-1:0] out_rs2_data;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_funct3;
  logic [6:0]      out_ctrl;

  logic            br_taken;
  logic [XLEN-1:0] br_target;

  modport slave (
    input  in_valid, in_pc, in_instr, hz_stall, flush,
    input  wb_we, wb_rd, wb_data, mem_we, mem_rd, mem_data, out_ready,
    output in_ready, out_valid, out_rs1, out_rs2, out_rd,
    output out_rs1_data, out_rs2_data, out_imm, out_funct3, out_ctrl,
    output br_taken, br_target
  );

  modport master (
    output in_valid, in_pc, in_instr, hz_stall, flush,
    output wb_we, wb_rd, wb_data, mem_we, mem_rd, mem_data, out_ready,
    input  in_ready, out_valid, out_rs1, out_rs2, out_rd,
    input  out_rs1_data, out_rs2_data, out_imm, out_funct3, out_ctrl,
    input  br_taken, br_target
  );
endinterface

// File: rtl/id_decode_pipe.sv
// ID stage: RV32I decode, forwarded register-file read, branch resolve and ID/EX register.
// Define ID_DECODE_BRANCH_EXT_EN to resolve BNE/BLT/BGE/BLTU/BGEU as well as BEQ.
module id_decode_pipe #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input logic             clk,
  input logic             rst,
  id_decode_pipe_if.slave bus
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // ctrl = {mem_to_reg, reg_write, mem_write, mem_read, alu_op[1:0], alu_src}
  localparam logic [6:0] CTRL_R     = 7'b0100010;
  localparam logic [6:0] CTRL_SUB   = 7'b0100100;
  localparam logic [6:0] CTRL_IMM   = 7'b0100001;
  localparam logic [6:0] CTRL_LOAD  = 7'b1101001;
  localparam logic [6:0] CTRL_STORE = 7'b0010001;
  localparam logic [6:0] CTRL_LUI   = 7'b0100001;
  localparam logic [6:0] CTRL_NONE  = 7'b0000000;

  typedef struct packed {
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic [6:0]      ctrl;
  } idex_t;

  logic [XLEN-1:0] rf_q [NREG];
  idex_t           idex_q;
  idex_t           idex_d;
  logic            out_valid_q;
  logic            out_valid_d;

  logic [31:0]     instr_s;
  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [AW-1:0]   rs1_s;
  logic [AW-1:0]   rs2_s;
  logic [AW-1:0]   rd_s;
  logic [XLEN-1:0] rs1_val_s;
  logic [XLEN-1:0] rs2_val_s;
  logic [XLEN-1:0] bimm_s;
  logic [XLEN-1:0] imm_s;
  logic [6:0]      ctrl_s;
  logic            is_branch_s;
  logic            br_cond_s;
  logic            in_ready_s;
  logic            accept_s;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] sv;
    sv = v;
    return XLEN'(sv);
  endfunction

  function automatic logic [XLEN-1:0] operand(
    input logic [AW-1:0]   idx,
    input logic [XLEN-1:0] rf_val,
    input logic            m_we,
    input logic [AW-1:0]   m_rd,
    input logic [XLEN-1:0] m_data,
    input logic            w_we,
    input logic [AW-1:0]   w_rd,
    input logic [XLEN-1:0] w_data
  );
    logic [XLEN-1:0] val;
    if (idx == '0) begin
      val = '0;
    end else if (m_we && (m_rd == idx)) begin
      val = m_data;
    end else if (w_we && (w_rd == idx)) begin
      val = w_data;
    end else begin
      val = rf_val;
    end
    return val;
  endfunction

  assign instr_s     = bus.in_instr;
  assign opcode_s    = instr_s[6:0];
  assign funct3_s    = instr_s[14:12];
  assign rd_s        = instr_s[7 +: AW];
  assign rs1_s       = instr_s[15 +: AW];
  assign rs2_s       = instr_s[20 +: AW];
  assign is_branch_s = (opcode_s == OPC_BRANCH);

  assign rs1_val_s = operand(rs1_s, rf_q[rs1_s], bus.mem_we, bus.mem_rd, bus.mem_data,
                             bus.wb_we, bus.wb_rd, bus.wb_data);
  assign rs2_val_s = operand(rs2_s, rf_q[rs2_s], bus.mem_we, bus.mem_rd, bus.mem_data,
                             bus.wb_we, bus.wb_rd, bus.wb_data);

  // Control word per opcode; branches and unknown opcodes become bubbles.
  always_comb begin
    ctrl_s = CTRL_NONE;
    case (opcode_s)
      OPC_R: begin
        if (instr_s[30] && (funct3_s == 3'b000)) begin
          ctrl_s = CTRL_SUB;
        end else begin
          ctrl_s = CTRL_R;
        end
      end
      OPC_IMM:   ctrl_s = CTRL_IMM;
      OPC_LOAD:  ctrl_s = CTRL_LOAD;
      OPC_STORE: ctrl_s = CTRL_STORE;
      OPC_LUI:   ctrl_s = CTRL_LUI;
      default:   ctrl_s = CTRL_NONE;
    endcase
  end

  assign bimm_s = sext32({{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25],
                          instr_s[11:8], 1'b0});

  // Immediate selection by instruction format; R-type and unknown carry no immediate.
  always_comb begin
    imm_s = '0;
    case (opcode_s)
      OPC_IMM, OPC_LOAD: imm_s = sext32({{20{instr_s[31]}}, instr_s[31:20]});
      OPC_STORE:         imm_s = sext32({{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]});
      OPC_BRANCH:        imm_s = bimm_s;
      OPC_LUI:           imm_s = sext32({instr_s[31:12], 12'h000});
      default:           imm_s = '0;
    endcase
  end

  // Branch condition on forwarded operands.
  always_comb begin
    br_cond_s = 1'b0;
    case (funct3_s)
      3'b000:  br_cond_s = (rs1_val_s == rs2_val_s);
`ifdef ID_DECODE_BRANCH_EXT_EN
      3'b001:  br_cond_s = (rs1_val_s != rs2_val_s);
      3'b100:  br_cond_s = ($signed(rs1_val_s) <  $signed(rs2_val_s));
      3'b101:  br_cond_s = ($signed(rs1_val_s) >= $signed(rs2_val_s));
      3'b110:  br_cond_s = (rs1_val_s <  rs2_val_s);
      3'b111:  br_cond_s = (rs1_val_s >= rs2_val_s);
`endif
      default: br_cond_s = 1'b0;
    endcase
  end

  assign in_ready_s = !rst && !bus.hz_stall && !bus.flush && (!out_valid_q || bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;

  assign bus.in_ready  = in_ready_s;
  assign bus.br_taken  = accept_s && is_branch_s && br_cond_s;
  assign bus.br_target = bus.in_pc + bimm_s;

  // ID/EX next state: flush squashes, accept loads, drain clears, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    idex_d      = idex_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept_s) begin
      out_valid_d     = 1'b1;
      idex_d.rs1      = rs1_s;
      idex_d.rs2      = rs2_s;
      idex_d.rd       = rd_s;
      idex_d.rs1_data = rs1_val_s;
      idex_d.rs2_data = rs2_val_s;
      idex_d.imm      = imm_s;
      idex_d.funct3   = funct3_s;
      idex_d.ctrl     = ctrl_s;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      idex_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      idex_q      <= idex_d;
    end
  end

  // Register file write port; entry 0 is never written so it always reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (bus.wb_we && (bus.wb_rd != '0)) begin
      rf_q[bus.wb_rd] <= bus.wb_data;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_rs1      = idex_q.rs1;
  assign bus.out_rs2      = idex_q.rs2;
  assign bus.out_rd       = idex_q.rd;
  assign bus.out_rs1_data = idex_q.rs1_data;
  assign bus.out_rs2_data = idex_q.rs2_data;
  assign bus.out_imm      = idex_q.imm;
  assign bus.out_funct3   = idex_q.funct3;
  assign bus.out_ctrl     = idex_q.ctrl;

endmodule

// File: tb/tb_id_decode_pipe.sv
// Bench for id_decode_pipe: spec-level model checked every cycle plus directed literal checks.
module tb_id_decode_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_decode_pipe_if bus ();
  id_decode_pipe dut (.clk(clk), .rst(rst), .bus(bus));

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd,
                                        input logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3,
                                        input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [31:0] v, input int rd);
    return {v[31:12], 5'(rd), 7'b0110111};
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] m_rf [32];
  bit          m_live = 1'b0;
  logic        m_valid;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_d1, m_d2, m_imm;
  logic [2:0]  m_f3;
  logic [6:0]  m_ctrl;

  function automatic logic [31:0] m_operand(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (bus.mem_we && bus.mem_rd == idx) return bus.mem_data;
    if (bus.wb_we && bus.wb_rd == idx) return bus.wb_data;
    return m_rf[idx];
  endfunction

  function automatic logic [6:0] m_ctrl_of(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110011: return (ins[30] && ins[14:12] == 3'd0) ? 7'b0100100 : 7'b0100010;
      7'b0010011: return 7'b0100001;
      7'b0000011: return 7'b1101001;
      7'b0100011: return 7'b0010001;
      7'b0110111: return 7'b0100001;
      default:    return 7'b0000000;
    endcase
  endfunction

  function automatic bit m_has_imm(input logic [31:0] ins);
    return ins[6:0] inside {7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111};
  endfunction

  function automatic logic [31:0] m_imm_of(input logic [31:0] ins);
    logic [11:0] s12;
    logic [12:0] b13;
    s12 = {ins[31:25], ins[11:7]};
    b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    case (ins[6:0])
      7'b0010011, 7'b0000011: return 32'(int'($signed(ins[31:20])));
      7'b0100011:             return 32'(int'($signed(s12)));
      7'b1100011:             return 32'(int'($signed(b13)));
      7'b0110111:             return {ins[31:12], 12'h000};
      default:                return 32'd0;
    endcase
  endfunction

  function automatic bit m_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef ID_DECODE_BRANCH_EXT_EN
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return int'(a) <  int'(b);
      3'd5: return int'(a) >= int'(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
`else
    return (f3 == 3'd0) && (a == b);
`endif
  endfunction

  function automatic bit m_in_ready();
    return !rst && !bus.hz_stall && !bus.flush && (!m_valid || bus.out_ready);
  endfunction

  function automatic bit m_br();
    logic [31:0] ins;
    ins = bus.in_instr;
    return bus.in_valid && m_in_ready() && ins[6:0] == 7'b1100011 &&
           m_cond(ins[14:12], m_operand(ins[19:15]), m_operand(ins[24:20]));
  endfunction

  // Model state advances on each clock edge from the inputs presented in that cycle.
  always @(posedge clk) begin : mdl
    logic [31:0] ins;
    bit acc;
    if (rst) begin
      m_live = 1'b1; m_valid = 1'b0;
      m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_d1 = '0; m_d2 = '0; m_imm = '0; m_f3 = '0; m_ctrl = '0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    end else begin
      ins = bus.in_instr;
      acc = bus.in_valid && m_in_ready();
      if (bus.flush) m_valid = 1'b0;
      else if (acc) begin
        m_valid = 1'b1;
        m_rs1 = ins[19:15]; m_rs2 = ins[24:20]; m_rd = ins[11:7]; m_f3 = ins[14:12];
        m_d1 = m_operand(ins[19:15]); m_d2 = m_operand(ins[24:20]);
        m_imm = m_imm_of(ins); m_ctrl = m_ctrl_of(ins);
      end else if (bus.out_ready) m_valid = 1'b0;
      if (bus.wb_we && bus.wb_rd != 5'd0) m_rf[bus.wb_rd] = bus.wb_data;
    end
  end

  // Compare process: DUT against model on every falling edge once reset has been seen.
  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready", bus.in_ready, m_in_ready());
      chk("br_taken", bus.br_taken, m_br());
      if (m_br()) chk("br_target", bus.br_target, bus.in_pc + m_imm_of(bus.in_instr));
      chk("out_valid", bus.out_valid, m_valid);
      if (m_valid) begin
        chk("out_rs1", bus.out_rs1, m_rs1);
        chk("out_rs2", bus.out_rs2, m_rs2);
        chk("out_rd", bus.out_rd, m_rd);
        chk("out_rs1_data", bus.out_rs1_data, m_d1);
        chk("out_rs2_data", bus.out_rs2_data, m_d2);
        chk("out_funct3", bus.out_funct3, m_f3);
        chk("out_ctrl", bus.out_ctrl, m_ctrl);
        if (m_ctrl != 7'd0 || m_imm != 32'd0) chk("out_imm", bus.out_imm, m_imm);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  logic [31:0] tbl_ins  [7];
  logic [6:0]  tbl_ctrl [7];
  logic [31:0] tbl_imm  [7];

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0;
    bus.hz_stall = 1'b0; bus.flush = 1'b0;
    bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.mem_we = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    bus.out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_ctrl", bus.out_ctrl, 7'd0);
    chk("rst_out_imm", bus.out_imm, 32'd0);
    rst = 1'b0;

    // ADDI x1,x0,5
    bus.in_valid = 1'b1; bus.in_instr = enc_i(5, 0, 0, 1, 7'b0010011);
    tick();
    bus.in_valid = 1'b0;
    chk("addi_valid", bus.out_valid, 1'b1);
    chk("addi_imm", bus.out_imm, 32'd5);
    chk("addi_ctrl", bus.out_ctrl, 7'b0100001);
    chk("addi_rs1_data", bus.out_rs1_data, 32'd0);
    tick();

    // ADD x4,x3,x3 with write-back bypass, then with MEM forwarding taking priority
    bus.wb_we = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'hA5;
    bus.in_valid = 1'b1; bus.in_instr = enc_r(0, 3, 3, 0, 4);
    tick();
    chk("wb_fwd_rs1", bus.out_rs1_data, 32'hA5);
    chk("wb_fwd_rs2", bus.out_rs2_data, 32'hA5);
    chk("add_ctrl", bus.out_ctrl, 7'b0100010);
    bus.mem_we = 1'b1; bus.mem_rd = 5'd3; bus.mem_data = 32'h11;
    tick();
    chk("mem_fwd_rs1", bus.out_rs1_data, 32'h11);
    chk("mem_fwd_rs2", bus.out_rs2_data, 32'h11);
    bus.mem_we = 1'b0; bus.wb_we = 1'b0; bus.in_valid = 1'b0;
    tick();

    // Format table, back-to-back accepts
    tbl_ins[0] = enc_i(-1, 1, 2, 8, 7'b0000011);  tbl_ctrl[0] = 7'b1101001; tbl_imm[0] = 32'hFFFFFFFF;
    tbl_ins[1] = enc_s(-4, 2, 1, 2);              tbl_ctrl[1] = 7'b0010001; tbl_imm[1] = 32'hFFFFFFFC;
    tbl_ins[2] = enc_u(32'h12345000, 9);          tbl_ctrl[2] = 7'b0100001; tbl_imm[2] = 32'h12345000;
    tbl_ins[3] = enc_r(32, 2, 1, 0, 10);          tbl_ctrl[3] = 7'b0100100; tbl_imm[3] = 32'd0;
    tbl_ins[4] = enc_r(32, 2, 1, 3, 11);          tbl_ctrl[4] = 7'b0100010; tbl_imm[4] = 32'd0;
    tbl_ins[5] = enc_i(-2048, 1, 0, 12, 7'b0010011); tbl_ctrl[5] = 7'b0100001; tbl_imm[5] = 32'hFFFFF800;
    tbl_ins[6] = 32'h0000006F;                    tbl_ctrl[6] = 7'b0000000; tbl_imm[6] = 32'd0;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1; bus.in_instr = tbl_ins[i];
      tick();
      chk("tbl_ctrl", bus.out_ctrl, tbl_ctrl[i]);
      if (i < 3 || i == 5) chk("tbl_imm", bus.out_imm, tbl_imm[i]);
    end
    bus.in_valid = 1'b0;
    tick();

    // Backpressure: A held for 3 cycles, B accepted when out_ready returns
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_instr = enc_i(-3, 1, 0, 6, 7'b0010011);
    tick();
    bus.in_instr = enc_i(9, 2, 0, 7, 7'b0010011);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", bus.in_ready, 1'b0);
      tick();
      chk("bp_hold_imm", bus.out_imm, 32'hFFFFFFFD);
      chk("bp_hold_rd", bus.out_rd, 5'd6);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.in_ready, 1'b1);
    tick();
    chk("bp_second_imm", bus.out_imm, 32'd9);
    bus.in_valid = 1'b0;

    // BEQ x1,x2,-8 at pc 4 with x1=x2=7
    bus.wb_we = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'd7;
    tick();
    bus.wb_rd = 5'd2;
    tick();
    bus.wb_we = 1'b0;
    bus.in_pc = 32'h4; bus.in_instr = enc_b(-8, 2, 1, 0); bus.in_valid = 1'b1;
    #1;
    chk("beq_taken", bus.br_taken, 1'b1);
    chk("beq_target", bus.br_target, 32'hFFFFFFFC);
    tick();
    chk("beq_bubble_valid", bus.out_valid, 1'b1);
    chk("beq_bubble_ctrl", bus.out_ctrl, 7'd0);
    bus.in_valid = 1'b0;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'd8;
    tick();
    bus.wb_we = 1'b0; bus.in_valid = 1'b1;
    #1;
    chk("beq_not_taken", bus.br_taken, 1'b0);
    // BNE x1,x2 (7 vs 8)
    bus.in_instr = enc_b(-8, 2, 1, 1);
    #1;
`ifdef ID_DECODE_BRANCH_EXT_EN
    chk("bne_taken", bus.br_taken, 1'b1);
`else
    chk("bne_ignored", bus.br_taken, 1'b0);
`endif
    tick();
    chk("bne_bubble_ctrl", bus.out_ctrl, 7'd0);
    // Hazard stall blocks a would-be-taken BEQ x1,x1
    bus.hz_stall = 1'b1; bus.in_instr = enc_b(16, 1, 1, 0);
    #1;
    chk("stall_br_taken", bus.br_taken, 1'b0);
    chk("stall_in_ready", bus.in_ready, 1'b0);
    tick();
    bus.hz_stall = 1'b0;

    // BLT / BLTU with x1=-1, x2=1
    bus.in_valid = 1'b0;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'hFFFFFFFF;
    tick();
    bus.wb_rd = 5'd2; bus.wb_data = 32'd1;
    tick();
    bus.wb_we = 1'b0; bus.in_valid = 1'b1; bus.in_instr = enc_b(8, 2, 1, 4);
    #1;
`ifdef ID_DECODE_BRANCH_EXT_EN
    chk("blt_taken", bus.br_taken, 1'b1);
`else
    chk("blt_ignored", bus.br_taken, 1'b0);
`endif
    bus.in_instr = enc_b(8, 2, 1, 6);
    #1;
    chk("bltu_not_taken", bus.br_taken, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    tick();

    // Flush coincident with a valid instruction
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_instr = enc_i(1, 0, 0, 2, 7'b0010011);
    #1;
    chk("flush_in_ready", bus.in_ready, 1'b0);
    tick();
    chk("flush_out_valid", bus.out_valid, 1'b0);
    bus.flush = 1'b0;

    // Reset in the middle of a stall
    bus.out_ready = 1'b0;
    tick();
    bus.hz_stall = 1'b1;
    tick();
    chk("pre_rst_valid", bus.out_valid, 1'b1);
    rst = 1'b1; bus.in_instr = enc_b(8, 0, 0, 0);
    #1;
    chk("rst_br_taken", bus.br_taken, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    tick();
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    rst = 1'b0; bus.hz_stall = 1'b0; bus.out_ready = 1'b1;
    bus.in_instr = enc_r(0, 2, 1, 0, 5);
    tick();
    chk("post_rst_rf_rs1", bus.out_rs1_data, 32'd0);
    chk("post_rst_rf_rs2", bus.out_rs2_data, 32'd0);
    bus.in_valid = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
